// File: rtl/tx_gain.sv
// Complex (I/Q) transmit gain stage with packet-aligned gain updates.
// Two-stage pipeline: multiply, then round-half-up and saturate; counts clipped beats.
module tx_gain #(
    parameter int unsigned SR_GAIN = 130,
    parameter int unsigned SR_CLR  = 131
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] in_TDATA,
    input  logic        in_TVALID,
    output logic        in_TREADY,
    input  logic        in_TLAST,
    output logic [31:0] out_TDATA,
    output logic        out_TVALID,
    input  logic        out_TREADY,
    output logic        out_TLAST,
    output logic [31:0] clip_count
);

    localparam int unsigned DW = 16;
    localparam int unsigned GW = 16;
    localparam int unsigned PW = 33;
    localparam logic [GW-1:0] GAIN_ONE = 16'h4000;

    typedef enum logic {BOUNDARY, IN_PKT} state_e;

    state_e               state_q, state_d;
    logic                 ready_q;
    logic [GW-1:0]        pend_q, pend_d;
    logic [GW-1:0]        act_q, act_d;
    logic                 v1_q, v1_d;
    logic                 last1_q, last1_d;
    logic signed [PW-1:0] pi_q, pi_d;
    logic signed [PW-1:0] pq_q, pq_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [31:0]          out_data_q, out_data_d;
    logic [31:0]          clip_q, clip_d;

    logic                 en;
    logic                 accept;
    logic                 clip_event;
    logic [GW-1:0]        beat_gain;
    logic signed [GW:0]   gain_s;
    logic signed [DW-1:0] in_i, in_q;
    logic [DW:0]          ri, rq;

    // upper settings bits are not part of the gain word
    logic unused_set_hi;
    assign unused_set_hi = ^set_data[31:16];

    // {clip flag, 16-bit result}: round half up at bit 14, then clamp to int16
    function automatic logic [DW:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        r = (p + 33'sd8192) >>> 14;
        if (r > 33'sd32767)       return {1'b1, 16'h7FFF};
        else if (r < -33'sd32768) return {1'b1, 16'h8000};
        else                      return {1'b0, r[DW-1:0]};
    endfunction

    assign en        = ~out_valid_q | out_TREADY;
    assign in_TREADY = ready_q & en;
    assign accept    = in_TVALID & in_TREADY;

    assign out_TDATA  = out_data_q;
    assign out_TVALID = out_valid_q;
    assign out_TLAST  = out_last_q;
    assign clip_count = clip_q;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        act_d       = act_q;
        v1_d        = v1_q;
        last1_d     = last1_q;
        pi_d        = pi_q;
        pq_d        = pq_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        clip_d      = clip_q;

        // first beat of a packet uses the pending gain before any same-cycle write lands
        beat_gain = (state_q == BOUNDARY) ? pend_q : act_q;
        gain_s    = {1'b0, beat_gain};
        in_i      = in_TDATA[31:16];
        in_q      = in_TDATA[15:0];
        ri        = round_sat(pi_q);
        rq        = round_sat(pq_q);

        if (set_stb && set_addr == 8'(SR_GAIN)) pend_d = set_data[GW-1:0];

        if (accept) begin
            if (state_q == BOUNDARY) act_d = pend_q;
            state_d = in_TLAST ? BOUNDARY : IN_PKT;
        end

        if (en) begin
            v1_d        = accept;
            last1_d     = in_TLAST;
            pi_d        = PW'(in_i) * PW'(gain_s);
            pq_d        = PW'(in_q) * PW'(gain_s);
            out_valid_d = v1_q;
            out_last_d  = last1_q;
            out_data_d  = {ri[DW-1:0], rq[DW-1:0]};
        end

        clip_event = en & v1_q & (ri[DW] | rq[DW]);
        if (set_stb && set_addr == 8'(SR_CLR))  clip_d = '0;
        else if (clip_event && clip_q != '1)    clip_d = clip_q + 32'd1;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= BOUNDARY;
            ready_q     <= 1'b0;
            pend_q      <= GAIN_ONE;
            act_q       <= GAIN_ONE;
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            pi_q        <= '0;
            pq_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            clip_q      <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= 1'b1;
            pend_q      <= pend_d;
            act_q       <= act_d;
            v1_q        <= v1_d;
            last1_q     <= last1_d;
            pi_q        <= pi_d;
            pq_q        <= pq_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            clip_q      <= clip_d;
        end
    end

endmodule

// File: doc/tx_gain.md
TX_GAIN -- requirements
Module: tx_gain

Interface
REQ-001 SHALL have parameter SR_GAIN, default 130, the settings address of the gain register.
REQ-002 SHALL have parameter SR_CLR, default 131, the settings address whose write clears the clip counter.
REQ-003 SHALL have port ap_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port ap_rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have set_stb, input, 1 bit, settings write strobe.
REQ-006 SHALL have set_addr, input, 8 bits, settings address.
REQ-007 SHALL have set_data, input, 32 bits, settings data.
REQ-008 SHALL have in_TDATA, input, 32 bits: I in [31:16] and Q in [15:0], both signed 16-bit.
REQ-009 SHALL have in_TVALID, input, 1 bit; in_TREADY, output, 1 bit; in_TLAST, input, 1 bit, end of packet.
REQ-010 SHALL have out_TDATA, output, 32 bits, in the same format as in_TDATA.
REQ-011 SHALL have out_TVALID, output, 1 bit; out_TREADY, input, 1 bit; out_TLAST, output, 1 bit.
REQ-012 SHALL have clip_count, output, 32 bits, the number of beats in which at least one component saturated.

Function
REQ-013 Gain format: unsigned Q2.14 from set_data[15:0]; 0x4000 = 1.0; set_data[31:16] ignored.
REQ-014 A write with set_stb=1 and set_addr=SR_GAIN SHALL load pending_gain on that edge.
REQ-015 Packet-boundary FSM SHALL have two states, BOUNDARY (reset state) and IN_PKT.
REQ-016 Accepting a beat in BOUNDARY SHALL copy pending_gain to active_gain, and that beat SHALL use the new gain.
REQ-017 Accepting a beat with in_TLAST=0 SHALL move the FSM to IN_PKT; accepting with in_TLAST=1 SHALL move to (or stay in) BOUNDARY.
REQ-018 A gain write mid-packet SHALL NOT affect the current packet; it takes effect on the first beat of the next packet.
REQ-019 A gain write on the same cycle as a BOUNDARY accept SHALL NOT apply to that beat, only to the next packet.
REQ-020 Arithmetic per component: signed 16 x unsigned 16 product (33 bits), add 0x2000, arithmetic shift right 14 (round half up), then saturate to [-32768, 32767].
REQ-021 Pipeline SHALL be 2 registered stages: stage 1 = multiply, stage 2 = round/saturate; TLAST SHALL travel with its data.
REQ-022 Latency SHALL be 2 cycles from input accept to out_TVALID when out_TREADY=1, with throughput of 1 beat per cycle.
REQ-023 Pipeline enable SHALL be en = ~out_TVALID | out_TREADY; both stages advance only when en=1.
REQ-024 in_TREADY SHALL equal en (a combinational path from out_TREADY is permitted); bubbles SHALL collapse.
REQ-025 While out_TVALID=1 and out_TREADY=0, out_TDATA and out_TLAST SHALL hold stable; no beat is lost or duplicated.
REQ-026 clip_count SHALL increment by 1 when a beat leaves stage 2 with either component saturated, and SHALL saturate at 0xFFFFFFFF.
REQ-027 A write to SR_CLR SHALL zero clip_count; if a clip increment occurs on the same cycle, the clear wins and the result is 0.
REQ-028 Writes to any other address SHALL be ignored.

Reset
REQ-029 While ap_rst_n=0, regardless of clock: out_TVALID=0, out_TLAST=0, out_TDATA=0, in_TREADY=0, clip_count=0, FSM=BOUNDARY, pending_gain=active_gain=0x4000.
REQ-030 Reset asserted mid-packet SHALL discard all in-flight beats; after release, the first accepted beat is treated as a packet start.
REQ-031 in_TREADY MAY rise on the first rising edge after ap_rst_n deasserts.

Verification
REQ-032 Unity gain, continuous ready: in I=1000, Q=-1000 -> out I=1000, Q=-1000 exactly 2 cycles later; clip_count=0.
REQ-033 Gain 0x8000: in I=20000, Q=-20000 -> out I=32767, Q=-32768; clip_count=1. A following beat I=100 -> out I=200, clip_count stays 1.
REQ-034 Gain 0x2000, rounding: I=3 -> 2; I=-3 -> -1; Q=1 -> 1; Q=-1 -> 0.
REQ-035 Mid-packet gain change: 4-beat packet at 0x4000, write 0x2000 after beat 2, then a second packet with I=1000 -> first packet outputs 1000 on all beats, second packet outputs 500.
REQ-036 Backpressure: hold out_TREADY=0 for 5 cycles with 3 beats offered -> in_TREADY drops after 2 beats buffered, out_TDATA stays stable, all 3 beats emerge in order with TLAST intact.
REQ-037 Clear/clip collision and reset: SR_CLR write on a clipping cycle -> clip_count=0; ap_rst_n pulsed low mid-packet -> outputs immediately at reset values and the next beat uses gain 0x4000.
